// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART command-frame parser: state encoding,
// frame constants and the frame checksum.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_CHK  = 3'd4
  } state_t;

  localparam int unsigned FRAME_LEN    = 5;
  localparam logic [7:0]  DEFAULT_SYNC = 8'hAA;

  function automatic logic [7:0] chk_xor(input logic [7:0] op,
                                         input logic [7:0] addr,
                                         input logic [7:0] data);
    return op ^ addr ^ data;
  endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer: counts idle cycles while enabled and flags the cycle
// on which the gap limit is reached without a clearing event.
module uart_gap_timer #(
  parameter int unsigned timeout_cycles = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LAST = 16'(timeout_cycles - 1);

  logic [15:0] count;

  // A clear in the expiry cycle wins, so a late-but-in-time byte is never lost.
  assign expired = enable && !clear && (count == LAST);

  always_ff @(posedge clock) begin
    if (reset || clear || expired || !enable) begin
      count <= 16'd0;
    end else begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles SYNC/CMD/ADDR/DATA/CHK frames from the UART byte stream, checks
// the XOR checksum and inter-byte gap, and presents commands on valid/ready.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter logic [7:0]  sync_byte      = DEFAULT_SYNC,
  parameter int unsigned timeout_cycles = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [7:0] cmd_op,
  output logic [7:0] cmd_addr,
  output logic [7:0] cmd_data,
  output logic       err_checksum,
  output logic       err_timeout,
  output logic       err_overrun
);

  state_t     state;
  logic [7:0] op_s;
  logic [7:0] addr_s;
  logic [7:0] data_s;
  logic       expired;
  logic       out_free;

  uart_gap_timer #(.timeout_cycles(timeout_cycles)) gap_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (rx_done),
    .enable  (state != S_IDLE),
    .expired (expired)
  );

  assign out_free = !cmd_valid || cmd_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      cmd_valid    <= 1'b0;
      cmd_op       <= 8'd0;
      cmd_addr     <= 8'd0;
      cmd_data     <= 8'd0;
      err_checksum <= 1'b0;
      err_timeout  <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      err_checksum <= 1'b0;
      err_timeout  <= 1'b0;
      err_overrun  <= 1'b0;
      if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
      end
      if (expired) begin
        state       <= S_IDLE;
        err_timeout <= 1'b1;
      end else if (rx_done) begin
        case (state)
          S_IDLE: if (rx_data == sync_byte) state <= S_CMD;
          S_CMD: begin
            op_s  <= rx_data;
            state <= S_ADDR;
          end
          S_ADDR: begin
            addr_s <= rx_data;
            state  <= S_DATA;
          end
          S_DATA: begin
            data_s <= rx_data;
            state  <= S_CHK;
          end
          S_CHK: begin
            state <= S_IDLE;
            if (chk_xor(op_s, addr_s, data_s) != rx_data) begin
              err_checksum <= 1'b1;
            end else if (out_free) begin
              // Loading here overrides the accept-clear above, keeping valid high.
              cmd_valid <= 1'b1;
              cmd_op    <= op_s;
              cmd_addr  <= addr_s;
              cmd_data  <= data_s;
            end else begin
              err_overrun <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Randomised and directed bench for uart_frame_parser against a byte-queue
// reference model of the frame protocol.
module tb_uart_frame_parser;

  localparam int unsigned T    = 100;
  localparam logic [7:0]  SYNC = 8'hAA;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_done = 1'b0;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  logic [7:0] cmd_op;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       err_checksum;
  logic       err_timeout;
  logic       err_overrun;

  always #5 clock = ~clock;

  uart_frame_parser #(.sync_byte(SYNC), .timeout_cycles(T)) dut (
    .clock        (clock),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_done      (rx_done),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_addr     (cmd_addr),
    .cmd_data     (cmd_data),
    .err_checksum (err_checksum),
    .err_timeout  (err_timeout),
    .err_overrun  (err_overrun)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: bytes of the current frame, idle edges since last byte.
  bit         in_frame;
  logic [7:0] fq[$];
  int         idle;
  bit         m_valid;
  logic [7:0] m_op, m_addr, m_data;
  bit         e_cs, e_to, e_ov;
  bit         rand_ready;

  task automatic model_reset();
    in_frame = 0; fq.delete(); idle = 0;
    m_valid = 0; m_op = 0; m_addr = 0; m_data = 0;
    e_cs = 0; e_to = 0; e_ov = 0;
  endtask

  task automatic model_step(input bit done, input logic [7:0] data, input bit ready);
    bit accept, loaded;
    accept = m_valid && ready;
    loaded = 0;
    e_cs = 0; e_to = 0; e_ov = 0;
    if (in_frame) begin
      if (done) begin
        fq.push_back(data);
        idle = 0;
        if (fq.size() == 5) begin
          if (fq[4] == (fq[1] ^ fq[2] ^ fq[3])) begin
            if (!m_valid || ready) begin
              loaded = 1;
              m_op = fq[1]; m_addr = fq[2]; m_data = fq[3];
            end else begin
              e_ov = 1;
            end
          end else begin
            e_cs = 1;
          end
          in_frame = 0;
          fq.delete();
        end
      end else begin
        idle++;
        if (idle == int'(T)) begin
          in_frame = 0;
          fq.delete();
          e_to = 1;
        end
      end
    end else if (done && data == SYNC) begin
      in_frame = 1;
      fq.delete();
      fq.push_back(data);
      idle = 0;
    end
    if (loaded) m_valid = 1;
    else if (accept) m_valid = 0;
  endtask

  task automatic compare_all();
    check("valid", 32'(cmd_valid), 32'(m_valid));
    check("fields", {8'd0, cmd_op, cmd_addr, cmd_data}, {8'd0, m_op, m_addr, m_data});
    check("errs", {29'd0, err_checksum, err_timeout, err_overrun}, {29'd0, e_cs, e_to, e_ov});
  endtask

  task automatic cycle(input bit done, input logic [7:0] data);
    if (rand_ready) cmd_ready = 1'($urandom_range(0, 1));
    rx_done = done;
    rx_data = data;
    model_step(done, data, cmd_ready);
    @(posedge clock);
    #1;
    compare_all();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) cycle(1'b0, 8'($urandom));
    cycle(1'b1, b);
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] a,
                            input logic [7:0] d, input logic [7:0] c);
    send_byte(SYNC, 0);
    send_byte(op, $urandom_range(0, 3));
    send_byte(a, $urandom_range(0, 3));
    send_byte(d, $urandom_range(0, 3));
    send_byte(c, $urandom_range(0, 3));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx_done = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    compare_all();
  endtask

  initial begin
    rand_ready = 0;
    model_reset();
    #1;
    do_reset();
    check("reset_valid", 32'(cmd_valid), 32'd0);

    // Good frame, consumer ready.
    cmd_ready = 1'b1;
    send_frame(8'h10, 8'h20, 8'h33, 8'h03);
    check("good_valid", 32'(cmd_valid), 32'd1);
    check("good_fields", {8'd0, cmd_op, cmd_addr, cmd_data}, 32'h00102033);
    cycle(1'b0, 8'd0);
    check("good_clear", 32'(cmd_valid), 32'd0);

    // Bad checksum, then the corrected frame.
    send_frame(8'h01, 8'h02, 8'h03, 8'hFF);
    check("bad_chk_pulse", 32'(err_checksum), 32'd1);
    cycle(1'b0, 8'd0);
    send_frame(8'h01, 8'h02, 8'h03, 8'h00);
    check("fixed_frame", {7'd0, cmd_valid, cmd_op, cmd_addr, cmd_data}, 32'h01010203);
    cycle(1'b0, 8'd0);

    // Backpressure: second good frame overruns.
    cmd_ready = 1'b0;
    send_frame(8'h10, 8'h20, 8'h33, 8'h03);
    send_frame(8'h11, 8'h22, 8'h44, 8'h77);
    check("overrun_pulse", 32'(err_overrun), 32'd1);
    repeat (3) cycle(1'b0, 8'd0);
    cmd_ready = 1'b1;
    cycle(1'b0, 8'd0);
    cmd_ready = 1'b0;
    cycle(1'b0, 8'd0);
    check("held_fields", {7'd0, cmd_valid, cmd_op, cmd_addr, cmd_data}, 32'h00102033);

    // Same-cycle accept and load.
    send_frame(8'h10, 8'h20, 8'h33, 8'h03);
    send_byte(SYNC, 1);
    send_byte(8'h11, 0);
    send_byte(8'h22, 2);
    send_byte(8'h44, 0);
    cmd_ready = 1'b1;
    cycle(1'b1, 8'h77);
    cmd_ready = 1'b0;
    check("swap_fields", {7'd0, cmd_valid, cmd_op, cmd_addr, cmd_data}, 32'h01112244);
    cmd_ready = 1'b1;
    cycle(1'b0, 8'd0);

    // Timeout: gap of T aborts, gap of T-1 idle cycles (byte on expiry edge) does not.
    send_byte(SYNC, 0);
    send_byte(8'h10, 0);
    repeat (T - 1) cycle(1'b0, 8'd0);
    check("no_early_to", 32'(err_timeout), 32'd0);
    cycle(1'b0, 8'd0);
    check("timeout_pulse", 32'(err_timeout), 32'd1);
    send_byte(8'h20, 0);
    send_byte(8'h33, 0);
    send_byte(8'h03, 0);
    cycle(1'b0, 8'd0);
    check("orphan_ignored", 32'(cmd_valid), 32'd0);
    send_frame(8'h05, 8'h06, 8'h07, 8'h04);
    send_byte(SYNC, 0);
    send_byte(8'h10, T - 1);
    send_byte(8'h20, 0);
    send_byte(8'h33, 0);
    send_byte(8'h03, 0);
    check("edge_byte_wins", {7'd0, cmd_valid, cmd_op, cmd_addr, cmd_data}, 32'h01102033);

    // Noise before sync, then reset mid-frame.
    send_byte(8'h55, 0);
    send_byte(8'h00, 0);
    send_frame(8'h21, 8'h43, 8'h65, 8'h07);
    send_byte(SYNC, 0);
    send_byte(8'h10, 0);
    send_byte(8'h20, 0);
    do_reset();
    check("reset_fields", {7'd0, cmd_valid, cmd_op, cmd_addr, cmd_data}, 32'd0);
    send_frame(8'h10, 8'h20, 8'h33, 8'h03);

    // Randomised traffic with random backpressure.
    rand_ready = 1;
    for (int i = 0; i < 300; i++) begin
      int kind;
      logic [7:0] op, a, d, c;
      kind = $urandom_range(0, 9);
      op = 8'($urandom); a = 8'($urandom); d = 8'($urandom);
      c = op ^ a ^ d;
      if (kind < 2) begin
        send_byte(8'($urandom), $urandom_range(0, 4));
      end else if (kind < 4) begin
        send_frame(op, a, d, c ^ 8'(1 << $urandom_range(0, 7)));
      end else if (kind == 4) begin
        send_byte(SYNC, 0);
        send_byte(op, $urandom_range(T - 2, T + 2));
        send_byte(a, 0);
        send_byte(d, 0);
        send_byte(c, 0);
      end else begin
        send_frame(op, a, d, c);
      end
    end
    rand_ready = 0;
    cmd_ready = 1'b1;
    repeat (T + 5) cycle(1'b0, 8'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
